addsub_seq: RTL and testbench

Parametrised, multi-cycle add/subtract unit, the successor to the team's fixed 4-bit ripple adder. It processes a WIDTH-bit operand pair CHUNK bits per cycle through one shared CHUNK-bit ripple slice. Subtract is a runtime mode, and the result carries signed-overflow and zero flags. Operands arrive and results leave over valid/ready handshakes, so the block drops into ALU datapaths that tolerate multi-cycle latency.

---
 rtl/addsub_pkg.sv | 19 +
 rtl/addsub_seq_if.sv | 28 ++
 rtl/addsub_chunk.sv | 24 ++
 rtl/addsub_seq.sv | 144 ++++++++++++++
 tb/tb_addsub_seq.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/addsub_pkg.sv
// Shared types and sizing helpers for the chunked add/subtract unit.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int nch(input int width, input int chunk);
    return width / chunk;
  endfunction

  // A single-slice configuration still needs a 1-bit index register.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/addsub_seq_if.sv
// Operand/result handshake bundle for addsub_seq.
interface addsub_seq_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             sub;
  logic             sat;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             c_out;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, c_in, sub, sat, out_ready,
    input  in_ready, out_valid, s, c_out, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, c_in, sub, sat, out_ready,
    output in_ready, out_valid, s, c_out, ovf, zero
  );
endinterface

// File: rtl/addsub_chunk.sv
// Combinational CHUNK-bit ripple slice of full-adder cells; cmsb is the
// carry into the slice MSB so the caller can form signed overflow.
module addsub_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             cmsb
);
  logic [CHUNK:0] c_s;

  assign c_s[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign s[i]     = a[i] ^ b[i] ^ c_s[i];
    assign c_s[i+1] = (a[i] & b[i]) | (c_s[i] & (a[i] ^ b[i]));
  end

  assign cout = c_s[CHUNK];
  assign cmsb = c_s[CHUNK-1];
endmodule

// File: rtl/addsub_seq.sv
// Multi-cycle add/subtract: WIDTH bits processed CHUNK bits per cycle.
// Optional signed saturation is enabled with the ADDSUB_SAT_EN macro.
module addsub_seq
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input logic         clk,
  input logic         rst_n,
  addsub_seq_if.slave bus
);
  localparam int            NCH      = nch(WIDTH, CHUNK);
  localparam int            IW       = idx_w(NCH);
  localparam logic [IW-1:0] LAST_IDX = IW'(NCH - 1);

  state_e           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, s_q, s_d;
  logic             carry_q, carry_d, c_out_q, c_out_d;
  logic             ovf_q, ovf_d, zero_q, zero_d;
`ifdef ADDSUB_SAT_EN
  logic             sat_q, sat_d;
`endif
  logic [CHUNK-1:0] a_chunk_s, b_chunk_s, sum_s;
  logic             cout_s, cmsb_s;

  // B is stored pre-inverted for subtract, so the slice only ever adds.
  assign a_chunk_s = a_q[int'(idx_q)*CHUNK +: CHUNK];
  assign b_chunk_s = b_q[int'(idx_q)*CHUNK +: CHUNK];

  addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a    (a_chunk_s),
    .b    (b_chunk_s),
    .cin  (carry_q),
    .s    (sum_s),
    .cout (cout_s),
    .cmsb (cmsb_s)
  );

  // Next-state, operand capture, slice accumulation and result latching.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    acc_d   = acc_q;
    s_d     = s_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
`ifdef ADDSUB_SAT_EN
    sat_d   = sat_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.c_in ^ bus.sub;
          idx_d   = {IW{1'b0}};
`ifdef ADDSUB_SAT_EN
          sat_d   = bus.sat;
`endif
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        acc_d[int'(idx_q)*CHUNK +: CHUNK] = sum_s;
        carry_d = cout_s;
        if (idx_q == LAST_IDX) begin
          c_out_d = cout_s;
          ovf_d   = cmsb_s ^ cout_s;
          s_d     = acc_d;
`ifdef ADDSUB_SAT_EN
          if (sat_q && (cmsb_s ^ cout_s)) begin
            s_d = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
          end else begin
            s_d = acc_d;
          end
`endif
          zero_d  = (s_d == {WIDTH{1'b0}});
          state_d = DONE;
        end else begin
          idx_d   = idx_q + IW'(1);
          state_d = RUN;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= {IW{1'b0}};
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      acc_q   <= {WIDTH{1'b0}};
      s_q     <= {WIDTH{1'b0}};
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
`ifdef ADDSUB_SAT_EN
      sat_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
`ifdef ADDSUB_SAT_EN
      sat_q   <= sat_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.s         = s_q;
  assign bus.c_out     = c_out_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;
endmodule

// File: tb/tb_addsub_seq.sv
// Table-driven, scoreboarded bench for addsub_seq (WIDTH=16, CHUNK=4).
module tb_addsub_seq;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  addsub_seq_if #(.WIDTH(16)) ifc ();
  addsub_seq #(.WIDTH(16), .CHUNK(4)) dut (.clk(clk), .rst_n(rst_n), .bus(ifc.slave));

`ifdef ADDSUB_SAT_EN
  localparam bit SAT_ON = 1'b1;
`else
  localparam bit SAT_ON = 1'b0;
`endif

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic        sat;
    logic [15:0] s;
    logic        cout;
    logic        ovf;
    logic        zero;
  } vec_t;

  vec_t tbl[11];
  vec_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic vec_t mk(input logic [15:0] a, input logic [15:0] b, input logic cin,
                              input logic sub, input logic sat, input logic [15:0] s,
                              input logic cout, input logic ovf, input logic zero);
    vec_t v;
    v.a = a; v.b = b; v.cin = cin; v.sub = sub; v.sat = sat;
    v.s = s; v.cout = cout; v.ovf = ovf; v.zero = zero;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Drive one operand pair, scramble inputs during RUN, check latency.
  task automatic start_op(input vec_t v);
    int cyc;
    @(negedge clk);
    chk("in_ready_idle", ifc.in_ready, 1);
    ifc.a = v.a; ifc.b = v.b; ifc.c_in = v.cin; ifc.sub = v.sub; ifc.sat = v.sat;
    ifc.in_valid = 1'b1;
    sb_q.push_back(v);
    @(posedge clk);
    @(negedge clk);
    ifc.a = 16'($urandom); ifc.b = 16'($urandom);
    ifc.sub = ~v.sub; ifc.c_in = ~v.cin; ifc.sat = ~v.sat;
    cyc = 0;
    while (ifc.out_valid !== 1'b1 && cyc < 40) begin
      chk("in_ready_busy", ifc.in_ready, 0);
      @(negedge clk);
      cyc++;
    end
    ifc.in_valid = 1'b0;
    chk("latency", cyc, 4);
  endtask

  task automatic check_out(output vec_t e);
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_empty actual=0 required=1");
      e = mk(16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    end else begin
      e = sb_q.pop_front();
      chk("s", ifc.s, e.s);
      chk("c_out", ifc.c_out, e.cout);
      chk("ovf", ifc.ovf, e.ovf);
      chk("zero", ifc.zero, e.zero);
    end
  endtask

  task automatic finish_op();
    ifc.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ifc.out_ready = 1'b0;
    chk("out_valid_drop", ifc.out_valid, 0);
    chk("in_ready_after_hs", ifc.in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    vec_t e;
    tbl[0]  = mk(16'h1234, 16'h0FFF, 1'b0, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0);
    tbl[1]  = mk(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    tbl[2]  = mk(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    tbl[3]  = mk(16'h0007, 16'h0005, 1'b1, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b0);
    tbl[4]  = mk(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, SAT_ON ? 16'h7FFF : 16'h8000,
                 1'b0, 1'b1, 1'b0);
    tbl[5]  = mk(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1, SAT_ON ? 16'h8000 : 16'h7FFF,
                 1'b1, 1'b1, 1'b0);
    tbl[6]  = mk(16'h8000, 16'h8000, 1'b0, 1'b0, 1'b1, SAT_ON ? 16'h8000 : 16'h0000,
                 1'b1, 1'b1, SAT_ON ? 1'b0 : 1'b1);
    tbl[7]  = mk(16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0);
    tbl[8]  = mk(16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    tbl[9]  = mk(16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);
    tbl[10] = mk(16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0);

    rst_n = 1'b0;
    ifc.in_valid = 1'b0; ifc.out_ready = 1'b0;
    ifc.a = 16'h0; ifc.b = 16'h0; ifc.c_in = 1'b0; ifc.sub = 1'b0; ifc.sat = 1'b0;
    #12;
    chk("rst_s", ifc.s, 0);
    chk("rst_c_out", ifc.c_out, 0);
    chk("rst_ovf", ifc.ovf, 0);
    chk("rst_zero", ifc.zero, 0);
    chk("rst_out_valid", ifc.out_valid, 0);
    chk("rst_in_ready", ifc.in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      start_op(tbl[i]);
      check_out(e);
      finish_op();
    end

    // Back-pressure: result must hold and no new operand may be taken.
    start_op(tbl[0]);
    check_out(e);
    for (int k = 0; k < 5; k++) begin
      ifc.in_valid = ~ifc.in_valid;
      ifc.a = 16'($urandom);
      @(negedge clk);
      chk("hold_s", ifc.s, e.s);
      chk("hold_flags", {ifc.c_out, ifc.ovf, ifc.zero}, {e.cout, e.ovf, e.zero});
      chk("hold_in_ready", ifc.in_ready, 0);
      chk("hold_out_valid", ifc.out_valid, 1);
    end
    ifc.in_valid = 1'b0;
    finish_op();
    repeat (3) @(negedge clk);
    chk("no_second_capture", ifc.out_valid, 0);
    chk("idle_in_ready", ifc.in_ready, 1);
    chk("idle_keeps_s", ifc.s, e.s);

    // Asynchronous reset during the second RUN cycle.
    ifc.a = 16'h1111; ifc.b = 16'h2222; ifc.c_in = 1'b0; ifc.sub = 1'b0; ifc.sat = 1'b0;
    ifc.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ifc.in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_s", ifc.s, 0);
    chk("abort_flags", {ifc.c_out, ifc.ovf, ifc.zero}, 3'b000);
    chk("abort_out_valid", ifc.out_valid, 0);
    chk("abort_in_ready", ifc.in_ready, 1);
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("abort_discarded", ifc.out_valid, 0);
    start_op(mk(16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0));
    check_out(e);
    finish_op();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
